fetch_stage: RTL and testbench

Instruction-fetch front end of the processor. It owns the program counter, issues addresses to a synchronous-read instruction memory, and presents `{out_valid, out_pc, out_instr}` to the IF/ID pipeline register (`syncRegister`) directly downstream. It honours a stall from the hazard unit without losing or duplicating the in-flight memory response, and redirects on a taken branch with a one-cycle bubble.

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory read port and the IF/ID output triple.
// master = fetch stage, slave = memory plus downstream pipeline register.
interface fetch_stage_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 128
);
    logic                   imem_en;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   out_valid;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        input  out_pc,
        input  out_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, reads a synchronous instruction memory,
// keeps a one-entry skid buffer across stalls and redirects on taken branches.
module fetch_stage #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 128,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned PC_STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    fetch_stage_if.master       bus
);

    localparam logic [PC_WIDTH-1:0] PC_RESET_VAL = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_INC       = PC_WIDTH'(PC_STEP);

    logic [PC_WIDTH-1:0]    pc_q;
    logic                   req_valid_q;
    logic [PC_WIDTH-1:0]    req_pc_q;
    logic                   hold_valid_q;
    logic [INSTR_WIDTH-1:0] hold_instr_q;
    logic                   out_valid_q;
    logic [PC_WIDTH-1:0]    out_pc_q;
    logic [INSTR_WIDTH-1:0] out_instr_q;

    logic                   imem_en;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   do_branch;
    logic                   do_stall;
    logic                   do_advance;
    logic                   capture;

    // A branch outranks a stall; reset outranks everything.
    always_comb begin
        do_branch  = !rst && branch_taken;
        do_stall   = !rst && !branch_taken && stall;
        do_advance = !rst && !branch_taken && !stall;
        capture    = do_stall && req_valid_q && !hold_valid_q;
    end

    always_comb begin
        imem_en   = 1'b0;
        imem_addr = pc_q;
        if (do_branch) begin
            imem_en   = 1'b1;
            imem_addr = branch_target;
        end else if (do_advance) begin
            imem_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= PC_RESET_VAL;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else if (do_branch) begin
            pc_q        <= branch_target + PC_INC;
            req_valid_q <= 1'b1;
            req_pc_q    <= branch_target;
        end else if (do_advance) begin
            pc_q        <= pc_q + PC_INC;
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
        end
    end

    // Memory data is only trustworthy in the first stall cycle, so grab it once.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else if (do_branch || do_advance) begin
            hold_valid_q <= 1'b0;
        end else if (capture) begin
            hold_valid_q <= 1'b1;
            hold_instr_q <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else if (do_branch) begin
            out_valid_q <= 1'b0;
        end else if (do_advance) begin
            out_valid_q <= req_valid_q;
            out_pc_q    <= req_pc_q;
            out_instr_q <= hold_valid_q ? hold_instr_q : bus.imem_rdata;
        end
    end

    assign bus.imem_en   = imem_en;
    assign bus.imem_addr = imem_addr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-order scoreboard of fetched words with due cycles,
// drained by a monitor that also checks bubbles, stall holds and reset values.
module tb_fetch_stage;

    localparam int PW = 8;
    localparam int IW = 128;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          branch_taken;
    logic [PW-1:0] branch_target;

    fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    fetch_stage #(
        .PC_WIDTH   (PW),
        .INSTR_WIDTH(IW),
        .RESET_PC   (0),
        .PC_STEP    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .bus          (bus)
    );

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
        int            due;
    } entry_t;

    entry_t        expq[$];
    logic [IW-1:0] mem[256];
    logic [PW-1:0] model_pc;
    int            cycle  = 0;
    int            checks = 0;
    int            passes = 0;

    bit            armed      = 0;
    logic          prev_rst   = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_br    = 1'b0;
    logic          shown_valid;
    logic [PW-1:0] shown_pc;
    logic [IW-1:0] shown_instr;
    bit            shown_known = 0;
    entry_t        head;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory returns garbage whenever it was not enabled the cycle before.
    always @(posedge clk) begin
        if (bus.imem_en)
            bus.imem_rdata <= mem[bus.imem_addr];
        else
            bus.imem_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic checkOutput(input string name, input logic [IW-1:0] actual,
                               input logic [IW-1:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
    endtask

    // Fetch order model: each issued word becomes due two cycles later; a stall
    // pushes every undelivered word back a cycle; branch/reset drop them all.
    function automatic void updateModel(input logic r, input logic s, input logic b,
                                        input logic [PW-1:0] t, input int n);
        entry_t e;
        if (r) begin
            expq.delete();
            model_pc = '0;
        end else if (b) begin
            expq.delete();
            e.pc = t; e.instr = mem[t]; e.due = n + 2;
            expq.push_back(e);
            model_pc = t + 8'd1;
        end else if (s) begin
            foreach (expq[i]) expq[i].due++;
        end else begin
            e.pc = model_pc; e.instr = mem[model_pc]; e.due = n + 2;
            expq.push_back(e);
            model_pc = model_pc + 8'd1;
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [PW-1:0] t);
        logic issue;
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        issue         = !r && (b || !s);
        #1;
        checkOutput("imem_en", IW'(bus.imem_en), IW'(issue));
        if (issue)
            checkOutput("imem_addr", IW'(bus.imem_addr), IW'(b ? t : model_pc));
        @(posedge clk);
        #1;
        updateModel(r, s, b, t, cycle - 1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (armed) begin
                if (prev_rst) begin
                    checkOutput("reset_valid", IW'(bus.out_valid), '0);
                    checkOutput("reset_pc", IW'(bus.out_pc), '0);
                    checkOutput("reset_instr", bus.out_instr, '0);
                    shown_valid = 1'b0;
                    shown_pc    = '0;
                    shown_instr = '0;
                    shown_known = 1;
                end else if (expq.size() > 0 && expq[0].due == cycle) begin
                    head = expq.pop_front();
                    checkOutput("out_valid", IW'(bus.out_valid), IW'(1'b1));
                    checkOutput("out_pc", IW'(bus.out_pc), IW'(head.pc));
                    checkOutput("out_instr", bus.out_instr, head.instr);
                    shown_valid = 1'b1;
                    shown_pc    = head.pc;
                    shown_instr = head.instr;
                    shown_known = 1;
                end else if (prev_stall && !prev_br) begin
                    checkOutput("hold_valid", IW'(bus.out_valid), IW'(shown_valid));
                    if (shown_known) begin
                        checkOutput("hold_pc", IW'(bus.out_pc), IW'(shown_pc));
                        checkOutput("hold_instr", bus.out_instr, shown_instr);
                    end
                end else begin
                    checkOutput("bubble_valid", IW'(bus.out_valid), '0);
                    shown_valid = 1'b0;
                    shown_known = 0;
                end
            end
            armed      = 1;
            prev_rst   = rst;
            prev_stall = stall;
            prev_br    = branch_taken;
        end
    end

    initial begin : driver
        logic r, s, b;
        for (int i = 0; i < 256; i++)
            mem[i] = {$urandom, $urandom, $urandom, 32'(32'hA000 + i)};
        model_pc = '0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h40);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h80);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFE);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(99) < 2);
            b = ($urandom_range(99) < 12);
            s = ($urandom_range(99) < 25);
            applyStimulus(r, s, b, 8'($urandom));
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
